traffic_light_ctrl: RTL
=======================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 The block SHALL have parameter GREEN_TICKS, default 4, meaning green phase length in ticks (legal range 1..255).
REQ-002 The block SHALL have parameter YELLOW_TICKS, default 2, meaning yellow phase length in ticks (legal range 1..255).
REQ-003 The block SHALL have parameter ALLRED_TICKS, default 1, meaning all-red phase length in ticks when no walk is served (legal range 1..255).
REQ-004 The block SHALL have parameter WALK_TICKS, default 3, meaning all-red phase length in ticks when a walk is served (legal range 1..255).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port tick, input, 1 bit: single-cycle time-base enable from the upstream divide-by-3 FSM (its out, high one cycle in three).
REQ-008 The block SHALL have port ped_req, input, 1 bit: pedestrian request, sampled every clk cycle, any width pulse.
REQ-009 The block SHALL have port ns_light, output, 3 bits: north-south lamp, one-hot {red,yellow,green}: 100 red, 010 yellow, 001 green.
REQ-010 The block SHALL have port ew_light, output, 3 bits: east-west lamp, same encoding.
REQ-011 The block SHALL have port walk, output, 1 bit: pedestrian walk lamp.

Function
REQ-012 States SHALL be NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B, visited cyclically in that order; no other transitions.
REQ-013 Lamp outputs SHALL be Moore decodes of state: NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; RED_A/RED_B ns=100 ew=100; EW_GREEN ns=100 ew=001; EW_YELLOW ns=100 ew=010.
REQ-014 An 8-bit phase counter SHALL increment only on cycles with tick=1; cycles with tick=0 SHALL change neither counter nor state.
REQ-015 On a tick cycle with counter == (current phase length - 1), state SHALL advance on that clk edge and counter SHALL load 0.
REQ-016 Phase length SHALL be GREEN_TICKS in green states, YELLOW_TICKS in yellow states, WALK_TICKS in RED_A/RED_B when walk_active=1, else ALLRED_TICKS.
REQ-017 A sticky flag ped_pend SHALL set on any cycle with ped_req=1 and hold until cleared.
REQ-018 On the edge entering RED_A or RED_B, walk_active SHALL load the pre-edge value of ped_pend, and ped_pend SHALL load ped_req (request coincident with entry is kept for the next red phase, not lost).
REQ-019 walk_active SHALL clear on the edge leaving RED_A/RED_B; walk SHALL equal walk_active.
REQ-020 walk SHALL never be 1 while either lamp is not 100.
REQ-021 tick held high continuously SHALL be legal: one counter step per cycle.
REQ-022 Exactly one lamp bit per direction SHALL be 1 in every cycle, including during reset.

Reset
REQ-023 reset=1 SHALL asynchronously force state NS_GREEN, counter 0, ped_pend 0, walk_active 0, without waiting for clk.
REQ-024 During and immediately after reset outputs SHALL be ns_light=001, ew_light=100, walk=0.
REQ-025 Reset asserted mid-phase (any state, any count, pending request) SHALL discard all progress and pending requests.
REQ-026 After reset release, the first NS_GREEN phase SHALL last the full GREEN_TICKS ticks.

Verification (defaults, tick one cycle in three as from the upstream FSM)
REQ-027 No ped_req, run 42 clk -> phase sequence NS_GREEN 4 ticks, NS_YELLOW 2, RED_A 1, EW_GREEN 4, EW_YELLOW 2, RED_B 1, then back to NS_GREEN at tick 14; walk stays 0.
REQ-028 One-cycle ped_req during NS_GREEN -> RED_A lasts 3 ticks with walk=1 and both lamps 100; RED_B lasts 1 tick with walk=0.
REQ-029 ped_req in the same cycle as the NS_YELLOW->RED_A edge, ped_pend previously 0 -> RED_A 1 tick walk=0; RED_B 3 ticks walk=1.
REQ-030 tick tied to 0 for 100 cycles after reset -> outputs stay ns=001 ew=100 walk=0; tick tied to 1 -> full cycle completes in 14 clk.
REQ-031 reset pulsed asynchronously (between clk edges) during RED_A with walk=1 -> outputs immediately ns=001 ew=100 walk=0; next NS_GREEN lasts 4 ticks.
REQ-032 Assertions on every cycle: lamp vectors one-hot, never both directions non-red, walk implies both red.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: six-phase Moore FSM paced by an external tick,
// with a sticky pedestrian request served as an extended all-red walk phase.
module traffic_light_ctrl #(
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] dbg_state
);

  // Handshake: none. tick is a one-cycle enable (may be held high); ped_req is a
  // level sampled every clk cycle and latched, so any pulse width is accepted.

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [7:0] GREEN_LEN  = 8'(GREEN_TICKS);
  localparam logic [7:0] YELLOW_LEN = 8'(YELLOW_TICKS);
  localparam logic [7:0] ALLRED_LEN = 8'(ALLRED_TICKS);
  localparam logic [7:0] WALK_LEN   = 8'(WALK_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] phase_len;
  logic       ped_pend;
  logic       walk_active;
  logic       phase_done;
  logic       enter_red;
  logic [2:0] ns_nxt;
  logic [2:0] ew_nxt;

  // Red phases stretch to the walk length only while a walk is being served.
  always_comb begin
    phase_len = ALLRED_LEN;
    case (state)
      NS_GREEN, EW_GREEN:   phase_len = GREEN_LEN;
      NS_YELLOW, EW_YELLOW: phase_len = YELLOW_LEN;
      RED_A, RED_B:         phase_len = walk_active ? WALK_LEN : ALLRED_LEN;
      default:              phase_len = ALLRED_LEN;
    endcase
  end

  assign phase_done = tick && (cnt == (phase_len - 8'd1));

  always_comb begin
    state_nxt = NS_GREEN;
    case (state)
      NS_GREEN:  state_nxt = NS_YELLOW;
      NS_YELLOW: state_nxt = RED_A;
      RED_A:     state_nxt = EW_GREEN;
      EW_GREEN:  state_nxt = EW_YELLOW;
      EW_YELLOW: state_nxt = RED_B;
      RED_B:     state_nxt = NS_GREEN;
      default:   state_nxt = NS_GREEN;
    endcase
  end

  assign enter_red = (state_nxt == RED_A) || (state_nxt == RED_B);

  // Lamp values for the state being entered, so the lamp registers track state exactly.
  always_comb begin
    ns_nxt = LAMP_RED;
    ew_nxt = LAMP_RED;
    case (state_nxt)
      NS_GREEN:  begin ns_nxt = LAMP_GREEN;  ew_nxt = LAMP_RED;    end
      NS_YELLOW: begin ns_nxt = LAMP_YELLOW; ew_nxt = LAMP_RED;    end
      EW_GREEN:  begin ns_nxt = LAMP_RED;    ew_nxt = LAMP_GREEN;  end
      EW_YELLOW: begin ns_nxt = LAMP_RED;    ew_nxt = LAMP_YELLOW; end
      default:   begin ns_nxt = LAMP_RED;    ew_nxt = LAMP_RED;    end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= NS_GREEN;
      cnt         <= 8'd0;
      ped_pend    <= 1'b0;
      walk_active <= 1'b0;
      ns_light    <= LAMP_GREEN;
      ew_light    <= LAMP_RED;
    end else if (phase_done) begin
      state    <= state_nxt;
      cnt      <= 8'd0;
      ns_light <= ns_nxt;
      ew_light <= ew_nxt;
      if (enter_red) begin
        // A request arriving on the entry edge is kept for the next red phase.
        walk_active <= ped_pend;
        ped_pend    <= ped_req;
      end else begin
        walk_active <= 1'b0;
        if (ped_req) ped_pend <= 1'b1;
      end
    end else begin
      if (tick) cnt <= cnt + 8'd1;
      if (ped_req) ped_pend <= 1'b1;
    end
  end

  assign walk      = walk_active;
  assign dbg_state = state;

endmodule
